// File: rtl/rob_pkg.sv
// Reorder buffer shared definitions: sizes, entry record and tag helpers.
package rob_pkg;

    localparam int unsigned XLEN         = 32;
    localparam int unsigned REG_ADDR_LEN = 5;
    localparam int unsigned ROB_TAG_LEN  = 3;
    // Must stay at most 2**ROB_TAG_LEN - 1 so the all-ones tag is never issued.
    localparam int unsigned ROB_SIZE     = 7;

    localparam logic [ROB_TAG_LEN-1:0] ROB_NO_TAG   = '1;
    localparam logic [ROB_TAG_LEN-1:0] ROB_LAST_TAG = ROB_TAG_LEN'(ROB_SIZE - 1);
    localparam logic [ROB_TAG_LEN-1:0] ROB_FULL_CNT = ROB_TAG_LEN'(ROB_SIZE);
    localparam logic [ROB_TAG_LEN-1:0] ROB_CNT_ONE  = ROB_TAG_LEN'(1);

    typedef struct packed {
        logic                    busy;
        logic                    ready;
        logic [REG_ADDR_LEN-1:0] dest;
        logic [XLEN-1:0]         value;
    } rob_entry_t;

    // True for tags naming a real entry; excludes the all-ones "no tag" value.
    function automatic logic tag_in_range(input logic [ROB_TAG_LEN-1:0] tag);
        return tag <= ROB_LAST_TAG;
    endfunction

endpackage

// File: rtl/rob_if.sv
// Reorder buffer bus: dispatch, CDB, operand read and retire signals.
// The flush signal exists only when ROB_FLUSH_EN is defined.
interface rob_if;
    import rob_pkg::*;

    logic                    dispatch_en;
    logic [REG_ADDR_LEN-1:0] dispatch_dest;
    logic [ROB_TAG_LEN-1:0]  assign_rob_tag;
    logic                    full;
    logic                    cdb_valid;
    logic [ROB_TAG_LEN-1:0]  cdb_rob_tag;
    logic [XLEN-1:0]         cdb_value;
    logic [ROB_TAG_LEN-1:0]  rd_tag1;
    logic [ROB_TAG_LEN-1:0]  rd_tag2;
    logic [XLEN-1:0]         rd_value1;
    logic [XLEN-1:0]         rd_value2;
    logic                    retire_valid;
    logic [REG_ADDR_LEN-1:0] retire_reg_addr;
    logic [ROB_TAG_LEN-1:0]  retire_rob_tag;
    logic [XLEN-1:0]         retire_value;
`ifdef ROB_FLUSH_EN
    logic                    flush;
`endif

    modport master (
`ifdef ROB_FLUSH_EN
        output flush,
`endif
        output dispatch_en, dispatch_dest, cdb_valid, cdb_rob_tag, cdb_value, rd_tag1, rd_tag2,
        input  assign_rob_tag, full, rd_value1, rd_value2, retire_valid, retire_reg_addr,
        input  retire_rob_tag, retire_value
    );

    modport slave (
`ifdef ROB_FLUSH_EN
        input  flush,
`endif
        input  dispatch_en, dispatch_dest, cdb_valid, cdb_rob_tag, cdb_value, rd_tag1, rd_tag2,
        output assign_rob_tag, full, rd_value1, rd_value2, retire_valid, retire_reg_addr,
        output retire_rob_tag, retire_value
    );

endinterface

// File: rtl/rob_ptr.sv
// Wrap-around modulo-Size pointer with increment enable and synchronous clear.
module rob_ptr #(
    parameter int unsigned Width = 3,
    parameter int unsigned Size  = 7
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr_i,
    input  logic             inc_i,
    output logic [Width-1:0] ptr_o
);
    localparam logic [Width-1:0] Last = Width'(Size - 1);
    localparam logic [Width-1:0] One  = Width'(1);

    logic [Width-1:0] ptr_q, ptr_d;

    // Next pointer: clear wins over increment, increment wraps at Size-1.
    always_comb begin
        ptr_d = ptr_q;
        if (clr_i) begin
            ptr_d = '0;
        end else if (inc_i) begin
            ptr_d = (ptr_q == Last) ? '0 : ptr_q + One;
        end
    end

    // Pointer register with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    assign ptr_o = ptr_q;

endmodule

// File: rtl/rob.sv
// Reorder buffer: circular buffer of ROB_SIZE entries, in-order retire, CDB writeback.
// Defining ROB_FLUSH_EN adds a flush input that returns the buffer to its reset state.
module rob
    import rob_pkg::*;
(
    input logic  clk,
    input logic  reset,
    rob_if.slave bus
);
    rob_entry_t             entries_q [ROB_SIZE];
    rob_entry_t             entries_d [ROB_SIZE];
    logic [ROB_TAG_LEN-1:0] count_q, count_d;
    logic [ROB_TAG_LEN-1:0] head, tail;
    logic                   full, retire, dispatch_ok, clr;

`ifdef ROB_FLUSH_EN
    assign clr = bus.flush;
`else
    assign clr = 1'b0;
`endif

    rob_ptr #(
        .Width (ROB_TAG_LEN),
        .Size  (ROB_SIZE)
    ) u_head (
        .clk   (clk),
        .reset (reset),
        .clr_i (clr),
        .inc_i (retire),
        .ptr_o (head)
    );

    rob_ptr #(
        .Width (ROB_TAG_LEN),
        .Size  (ROB_SIZE)
    ) u_tail (
        .clk   (clk),
        .reset (reset),
        .clr_i (clr),
        .inc_i (dispatch_ok),
        .ptr_o (tail)
    );

    // Outputs and handshake decisions, all from registered state (plus flush).
    always_comb begin
        full        = (count_q == ROB_FULL_CNT);
        retire      = (count_q != '0) && entries_q[head].ready && !clr;
        // A full buffer refuses dispatch even when the head retires this cycle.
        dispatch_ok = bus.dispatch_en && !full && !clr;

        bus.assign_rob_tag  = tail;
        bus.full            = full;
        bus.retire_valid    = retire;
        bus.retire_reg_addr = entries_q[head].dest;
        bus.retire_rob_tag  = head;
        bus.retire_value    = entries_q[head].value;
        // No CDB bypass: the map table marks ready on the same edge we store the value.
        bus.rd_value1 = tag_in_range(bus.rd_tag1) ? entries_q[bus.rd_tag1].value : '0;
        bus.rd_value2 = tag_in_range(bus.rd_tag2) ? entries_q[bus.rd_tag2].value : '0;
    end

    // Next entry array and occupancy count.
    always_comb begin
        entries_d = entries_q;
        count_d   = count_q;
        if (clr) begin
            for (int i = 0; i < ROB_SIZE; i++) begin
                entries_d[i] = '0;
            end
            count_d = '0;
        end else begin
            // CDB results land only in live entries; stray or "no tag" broadcasts are dropped.
            if (bus.cdb_valid && tag_in_range(bus.cdb_rob_tag) &&
                entries_q[bus.cdb_rob_tag].busy) begin
                entries_d[bus.cdb_rob_tag].ready = 1'b1;
                entries_d[bus.cdb_rob_tag].value = bus.cdb_value;
            end
            if (retire) begin
                entries_d[head] = '0;
            end
            if (dispatch_ok) begin
                entries_d[tail] = '{busy: 1'b1, ready: 1'b0, dest: bus.dispatch_dest, value: '0};
            end
            if (dispatch_ok && !retire) begin
                count_d = count_q + ROB_CNT_ONE;
            end else if (!dispatch_ok && retire) begin
                count_d = count_q - ROB_CNT_ONE;
            end
        end
    end

    // Entry and count registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < ROB_SIZE; i++) begin
                entries_q[i] <= '0;
            end
            count_q <= '0;
        end else begin
            entries_q <= entries_d;
            count_q   <= count_d;
        end
    end

    logic unused_no_tag;
    assign unused_no_tag = ^ROB_NO_TAG;

endmodule

// File: tb/tb_rob.sv
// Randomised scoreboard bench for rob; flush cases run when ROB_FLUSH_EN is defined.
module tb_rob;
    import rob_pkg::*;

    typedef struct {
        int          tag;
        int          dest;
        bit          rdy;
        logic [31:0] val;
    } ment_t;

    typedef struct {
        int tag;
        int dest;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    rob_if bus ();

    rob dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    ment_t       mq[$];      // in-flight instructions, oldest first
    exp_t        exp_q[$];   // expected retire order
    logic [31:0] val_of[8];  // latest result per tag
    int          next_tag;
    int          n_cmp = 0;
    int          n_fail = 0;
    int          n_ret = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] model_rd(input int t);
        foreach (mq[i]) if (mq[i].tag == t) return mq[i].rdy ? mq[i].val : 32'h0;
        return 32'h0;
    endfunction

    task automatic model_clear();
        mq.delete();
        exp_q.delete();
        next_tag = 0;
        foreach (val_of[i]) val_of[i] = '0;
    endtask

    // Behavioural update for one clock edge.
    task automatic model_edge(input bit de, input int dd, input bit cv, input int ct,
                              input logic [31:0] cval, input bit fl, input bit rst);
        bit ret, was_full;
        if (rst || fl) begin
            model_clear();
            return;
        end
        ret      = (mq.size() > 0) && mq[0].rdy;
        was_full = (mq.size() == ROB_SIZE);
        if (cv) begin
            foreach (mq[i]) begin
                if (mq[i].tag == ct) begin
                    mq[i].rdy  = 1'b1;
                    mq[i].val  = cval;
                    val_of[ct] = cval;
                end
            end
        end
        if (ret) void'(mq.pop_front());
        if (de && !was_full) begin
            mq.push_back('{tag: next_tag, dest: dd, rdy: 1'b0, val: 32'h0});
            exp_q.push_back('{tag: next_tag, dest: dd});
            val_of[next_tag] = '0;
            next_tag = (next_tag + 1) % ROB_SIZE;
        end
    endtask

    // Retire monitor: every DUT retire must match the oldest outstanding dispatch.
    always @(negedge clk) begin
        if (bus.retire_valid === 1'b1) begin
            n_ret++;
            if (exp_q.size() == 0) begin
                chk("retire_unexpected", 64'(bus.retire_valid), 64'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("retire_rob_tag", 64'(bus.retire_rob_tag), 64'(e.tag));
                chk("retire_reg_addr", 64'(bus.retire_reg_addr), 64'(e.dest));
                chk("retire_value", 64'(bus.retire_value), 64'(val_of[e.tag]));
            end
        end
    end

    task automatic step(input bit de, input int dd, input bit cv, input int ct,
                        input logic [31:0] cval, input bit fl, input bit rst);
        @(negedge clk);
        chk("assign_rob_tag", 64'(bus.assign_rob_tag), 64'(next_tag));
        chk("full", 64'(bus.full), 64'(mq.size() == ROB_SIZE));
        chk("retire_valid", 64'(bus.retire_valid), 64'((mq.size() > 0) && mq[0].rdy));
        #2;
        reset             = rst;
        bus.dispatch_en   = de;
        bus.dispatch_dest = 5'(dd);
        bus.cdb_valid     = cv;
        bus.cdb_rob_tag   = 3'(ct);
        bus.cdb_value     = cval;
`ifdef ROB_FLUSH_EN
        bus.flush         = fl;
`endif
        bus.rd_tag1       = 3'($urandom_range(0, 7));
        bus.rd_tag2       = 3'($urandom_range(0, 7));
        #1;
        chk("rd_value1", 64'(bus.rd_value1), 64'(model_rd(int'(bus.rd_tag1))));
        chk("rd_value2", 64'(bus.rd_value2), 64'(model_rd(int'(bus.rd_tag2))));
`ifdef ROB_FLUSH_EN
        if (fl) chk("retire_valid_in_flush", 64'(bus.retire_valid), 64'd0);
`endif
        @(posedge clk);
        model_edge(de, dd, cv, ct, cval, fl, rst);
    endtask

    task automatic idle();
        step(1'b0, 0, 1'b0, 0, 32'h0, 1'b0, 1'b0);
    endtask

    task automatic dispatch(input int dd);
        step(1'b1, dd, 1'b0, 0, 32'h0, 1'b0, 1'b0);
    endtask

    task automatic cdb(input int t, input logic [31:0] v, input bit de);
        step(de, 3, 1'b1, t, v, 1'b0, 1'b0);
    endtask

    // Direct operand read between edges.
    task automatic peek(input int t, input logic [31:0] exp);
        #1;
        bus.rd_tag1 = 3'(t);
        #1;
        chk("rd_peek", 64'(bus.rd_value1), 64'(exp));
    endtask

    initial begin
        int live[$];
        int ct;
        bit fl;
        reset             = 1'b1;
        bus.dispatch_en   = 1'b0;
        bus.dispatch_dest = '0;
        bus.cdb_valid     = 1'b0;
        bus.cdb_rob_tag   = '0;
        bus.cdb_value     = '0;
        bus.rd_tag1       = '0;
        bus.rd_tag2       = '0;
`ifdef ROB_FLUSH_EN
        bus.flush         = 1'b0;
`endif
        repeat (2) @(posedge clk);
        model_clear();
        @(negedge clk);
        chk("reset_retire_reg_addr", 64'(bus.retire_reg_addr), 64'd0);
        chk("reset_retire_rob_tag", 64'(bus.retire_rob_tag), 64'd0);
        chk("reset_retire_value", 64'(bus.retire_value), 64'd0);
        chk("reset_rd_value1", 64'(bus.rd_value1), 64'd0);

        // Three dispatches, then two out-of-order CDB results.
        dispatch(5);
        dispatch(6);
        dispatch(9);
        idle();
        cdb(1, 32'hAA, 1'b0);
        peek(1, 32'hAA);
        cdb(0, 32'h55, 1'b0);
        idle();
        idle();
        idle();

        // Fill to full, try an extra dispatch, then retire while dispatch stays asserted.
        repeat (7) dispatch($urandom_range(0, 31));
        chk("full_after_fill", 64'(mq.size()), 64'(ROB_SIZE));
        cdb(mq[0].tag, 32'h1234, 1'b1);
        dispatch(17);
        idle();

        // Broadcasts to the no-tag value and to a free entry change nothing.
        cdb(7, 32'hDEAD, 1'b0);
        cdb(next_tag, 32'hBEEF, 1'b0);
        idle();

        // Randomised dispatch/CDB/retire traffic with rare resets.
        for (int r = 0; r < 400; r++) begin
            live.delete();
            foreach (mq[i]) if (!mq[i].rdy) live.push_back(mq[i].tag);
            if (live.size() > 0 && $urandom_range(0, 4) != 0) begin
                ct = live[$urandom_range(0, live.size() - 1)];
            end else begin
                ct = $urandom_range(0, 7);
            end
            fl = 1'b0;
`ifdef ROB_FLUSH_EN
            fl = ($urandom_range(0, 99) == 0);
`endif
            step($urandom_range(0, 3) != 0, $urandom_range(0, 31), $urandom_range(0, 2) != 0, ct,
                 $urandom, fl, $urandom_range(0, 149) == 0);
        end

`ifdef ROB_FLUSH_EN
        // Flush with a ready head, dispatch and CDB all in the same cycle.
        step(1'b0, 0, 1'b0, 0, 32'h0, 1'b0, 1'b1);
        repeat (4) dispatch($urandom_range(0, 31));
        cdb(0, 32'h77, 1'b0);
        step(1'b1, 4, 1'b1, 1, 32'h99, 1'b1, 1'b0);
        idle();
`endif
        // Reset asserted mid-fill drops the in-flight dispatch.
        repeat (3) dispatch($urandom_range(0, 31));
        step(1'b1, 8, 1'b0, 0, 32'h0, 1'b0, 1'b1);
        idle();
        idle();

        chk("retires_observed", 64'(n_ret > 0), 64'd1);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
